// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit that owns the HI/LO register pair and serves MTHI/MTLO/MFHI/MFLO.
// Latency: a mult/div result lands in HI/LO 33 edges after issue (32 iterations + 1 fix-up); MTHI/MTLO take 1 edge.
// Backpressure: while busy, stall is raised combinationally for any HI/LO user; requests seen while busy are ignored.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_val_i,
   input  logic [WIDTH-1:0] rt_val_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   input  logic             hilo_read_i,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;   // product / quotient sign
   logic             neg_rem_q, neg_rem_d;   // remainder sign
   logic [WIDTH:0]   acc_q, acc_d;           // product upper half / partial remainder
   logic [WIDTH-1:0] mq_q, mq_d;             // multiplier / dividend-then-quotient
   logic [WIDTH-1:0] opd_q, opd_d;           // multiplicand / divisor magnitude
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;

   // Issue-time operand conditioning: magnitudes for signed ops, raw dividend on divide-by-zero
   logic             op_signed, div_zero;
   logic [WIDTH-1:0] rs_abs, rt_abs;
   assign op_signed = ~op_i[0];
   assign div_zero  = op_i[1] && (rt_val_i == '0);
   assign rs_abs    = (op_signed && rs_val_i[WIDTH-1]) ? -rs_val_i : rs_val_i;
   assign rt_abs    = (op_signed && rt_val_i[WIDTH-1]) ? -rt_val_i : rt_val_i;

   // One iteration of shift-add multiply and restoring divide, plus the final signed product
   logic [WIDTH:0]     mul_sum, div_shift;
   logic [WIDTH+1:0]   div_trial;
   logic [2*WIDTH-1:0] prod_raw, prod_fixed;
   assign mul_sum    = acc_q + (mq_q[0] ? {1'b0, opd_q} : '0);
   assign div_shift  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
   assign div_trial  = {1'b0, div_shift} - {2'b00, opd_q};
   assign prod_raw   = {acc_q[WIDTH-1:0], mq_q};
   assign prod_fixed = neg_res_q ? -prod_raw : prod_raw;

   // Next-state and datapath: issue in IDLE, iterate in RUN, sign-fix and commit HI/LO in FIX
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      mq_d      = mq_q;
      opd_d     = opd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_RUN;
               cnt_d     = LAST_ITER;
               is_div_d  = op_i[1];
               neg_res_d = op_signed & ~div_zero & (rs_val_i[WIDTH-1] ^ rt_val_i[WIDTH-1]);
               neg_rem_d = op_signed & ~div_zero & rs_val_i[WIDTH-1];
               acc_d     = '0;
               if (op_i[1]) begin
                  mq_d  = div_zero ? rs_val_i : rs_abs;
                  opd_d = rt_abs;
               end else begin
                  mq_d  = rt_abs;
                  opd_d = rs_abs;
               end
            end else begin
               if (mthi_i) hi_d = rs_val_i;
               if (mtlo_i) lo_d = rs_val_i;
            end
         end
         S_RUN: begin
            if (is_div_q) begin
               acc_d = div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
               mq_d  = {mq_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
            end else begin
               acc_d = {1'b0, mul_sum[WIDTH:1]};
               mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_FIX: begin
            if (is_div_q) begin
               lo_d = neg_res_q ? -mq_q : mq_q;
               hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end else begin
               hi_d = prod_fixed[2*WIDTH-1:WIDTH];
               lo_d = prod_fixed[WIDTH-1:0];
            end
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset clearing control, accumulators and HI/LO
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         mq_q      <= '0;
         opd_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         mq_q      <= mq_d;
         opd_q     <= opd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy_o  = (state_q != S_IDLE);
   assign stall_o = busy_o & (hilo_read_i | start_i | mthi_i | mtlo_i);
   assign done_o  = done_q;
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed hazard/reset steps plus randomized mult/div against an arithmetic model.
// Timing: inputs change 1 time unit after a rising edge; outputs sampled at that point or later in the cycle.
// Every wait on done is bounded; an expired bound shows up as a latency FAIL.
module tb_muldiv_sequencer;
   logic        clk_i = 1'b0;
   logic        reset_i, start_i, mthi_i, mtlo_i, hilo_read_i;
   logic [1:0]  op_i;
   logic [31:0] rs_val_i, rt_val_i;
   logic        busy_o, stall_o, done_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
      .rs_val_i(rs_val_i), .rt_val_i(rt_val_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
      .hilo_read_i(hilo_read_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Architectural result of a MIPS mult/div, computed with 64-bit arithmetic
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] ehi, output logic [31:0] elo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: p = sa * sb;
         2'd1: p = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else            p = {a % b, a / b};
         end
      endcase
      ehi = p[63:32];
      elo = p[31:0];
   endfunction

   // Issue one op, wait for done (bounded), check latency, busy length, HI/LO hold and result
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] ehi, elo, ohi, olo;
      int n, bc;
      bit hold;
      model(op, a, b, ehi, elo);
      ohi = hi_o;
      olo = lo_o;
      op_i = op; rs_val_i = a; rt_val_i = b; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      rs_val_i = $urandom;
      rt_val_i = $urandom;
      n = 0; bc = 0; hold = 1'b1;
      while (!done_o && n < 100) begin
         if (busy_o) bc++;
         if (hi_o !== ohi || lo_o !== olo) hold = 1'b0;
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd33);
      check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
      check({tag, "_hold"}, 64'(hold), 64'd1);
      check({tag, "_hi"}, 64'(hi_o), 64'(ehi));
      check({tag, "_lo"}, 64'(lo_o), 64'(elo));
      tick();
      check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
   endtask

   initial begin
      logic [31:0] ehi, elo, phi, plo;
      int n, sbad;
      bit seen;

      reset_i = 1'b1; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; hilo_read_i = 1'b0;
      op_i = 2'd0; rs_val_i = '0; rt_val_i = '0;
      tick(); tick();
      reset_i = 1'b0;
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      check("rst_stall", 64'(stall_o), 64'd0);

      // MTHI then MTLO in IDLE, then both together
      mthi_i = 1'b1; rs_val_i = 32'h1234_5678; #1;
      check("mthi_idle_stall", 64'(stall_o), 64'd0);
      tick(); mthi_i = 1'b0;
      check("mthi_hi", 64'(hi_o), 64'h1234_5678);
      mtlo_i = 1'b1; rs_val_i = 32'h9ABC_DEF0; #1;
      check("mtlo_idle_stall", 64'(stall_o), 64'd0);
      tick(); mtlo_i = 1'b0;
      check("mtlo_lo", 64'(lo_o), 64'h9ABC_DEF0);
      check("mtlo_hi_kept", 64'(hi_o), 64'h1234_5678);
      mthi_i = 1'b1; mtlo_i = 1'b1; rs_val_i = 32'h0BAD_F00D;
      tick(); mthi_i = 1'b0; mtlo_i = 1'b0;
      check("mthilo_hi", 64'(hi_o), 64'h0BAD_F00D);
      check("mthilo_lo", 64'(lo_o), 64'h0BAD_F00D);

      // Directed arithmetic cases with spelled-out results
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      check("multu_max_hi_const", 64'(hi_o), 64'hFFFF_FFFE);
      check("multu_max_lo_const", 64'(lo_o), 64'h0000_0001);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      check("mult_neg_lo_const", 64'(lo_o), 64'hFFFF_FFEB);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
      check("div_neg_lo_const", 64'(lo_o), 64'hFFFF_FFFD);
      check("div_neg_hi_const", 64'(hi_o), 64'hFFFF_FFFF);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      check("div_ovf_lo_const", 64'(lo_o), 64'h8000_0000);
      check("div_ovf_hi_const", 64'(hi_o), 64'h0000_0000);
      run_op(2'd3, 32'd100, 32'd0, "divu_zero");
      check("divu_zero_hi_const", 64'(hi_o), 64'h0000_0064);
      run_op(2'd2, 32'hFFFF_FF9C, 32'd0, "div_zero_neg");

      // start with mthi/mtlo in IDLE: start wins, HI/LO untouched until the op commits
      phi = hi_o; plo = lo_o;
      op_i = 2'd1; rs_val_i = 32'd5; rt_val_i = 32'd6; start_i = 1'b1; mthi_i = 1'b1; mtlo_i = 1'b1;
      tick();
      start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
      check("start_wins_hi", 64'(hi_o), 64'(phi));
      check("start_wins_lo", 64'(lo_o), 64'(plo));
      n = 0;
      while (!done_o && n < 100) begin tick(); n++; end
      check("start_wins_latency", 64'(n), 64'd33);
      check("start_wins_result_lo", 64'(lo_o), 64'd30);
      tick();

      // Hazards: MFHI stalled from cycle 5, a second start at cycle 10 is ignored
      model(2'd3, 32'd1000, 32'd7, ehi, elo);
      op_i = 2'd3; rs_val_i = 32'd1000; rt_val_i = 32'd7; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n = 0; sbad = 0;
      while (n < 100) begin
         hilo_read_i = (n >= 5);
         start_i = (n == 10);
         if (n == 10) begin op_i = 2'd0; rs_val_i = 32'hAAAA_5555; rt_val_i = 32'd3; end
         #1;
         if (done_o) break;
         if (n >= 5 && stall_o !== 1'b1) sbad++;
         if (n == 10) check("second_start_stall", 64'(stall_o), 64'd1);
         tick();
         n++;
      end
      start_i = 1'b0;
      check("haz_latency", 64'(n), 64'd33);
      check("haz_stall_while_busy", 64'(sbad), 64'd0);
      check("haz_stall_done_cycle", 64'(stall_o), 64'd0);
      check("haz_hi", 64'(hi_o), 64'(ehi));
      check("haz_lo", 64'(lo_o), 64'(elo));

      // Back-to-back: start in the done cycle is accepted; MTHI during it stalls and is dropped
      hilo_read_i = 1'b0;
      phi = hi_o;
      op_i = 2'd1; rs_val_i = 32'h1234; rt_val_i = 32'h10; start_i = 1'b1; #1;
      check("b2b_stall", 64'(stall_o), 64'd0);
      tick();
      start_i = 1'b0;
      check("b2b_busy", 64'(busy_o), 64'd1);
      mthi_i = 1'b1; rs_val_i = 32'hDEAD_BEEF; #1;
      check("mthi_busy_stall", 64'(stall_o), 64'd1);
      tick();
      mthi_i = 1'b0;
      check("mthi_busy_hi", 64'(hi_o), 64'(phi));
      n = 1;
      while (!done_o && n < 100) begin tick(); n++; end
      check("b2b_latency", 64'(n), 64'd33);
      check("b2b_lo", 64'(lo_o), 64'h0001_2340);
      check("b2b_hi", 64'(hi_o), 64'd0);
      tick();

      // Reset in the middle of RUN
      op_i = 2'd0; rs_val_i = 32'h7654_3210; rt_val_i = 32'hFEDC_BA98; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (9) tick();
      check("pre_reset_busy", 64'(busy_o), 64'd1);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("mid_reset_busy", 64'(busy_o), 64'd0);
      check("mid_reset_hi", 64'(hi_o), 64'd0);
      check("mid_reset_lo", 64'(lo_o), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         if (done_o) seen = 1'b1;
         tick();
      end
      check("mid_reset_no_done", 64'(seen), 64'd0);
      run_op(2'd1, 32'd6, 32'd7, "multu_after_reset");
      check("multu_after_reset_lo_const", 64'(lo_o), 64'd42);

      // Randomized ops, with small operands and zero divisors mixed in
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
               (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom);
         run_op(rop, ra, rb, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage, runs a 32-iteration shift-add or restoring-divide loop, and writes HI/LO on completion. While the loop runs it raises a stall request for any instruction that touches HI/LO: MFHI, MFLO, MTHI, MTLO or another mult/div. It also services MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO result path.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  EX stage holds a mult/div this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand/dividend; also the MTHI/MTLO write data
- rt_val  in  WIDTH  multiplier/divisor
- mthi  in  1  write rs_val to HI
- mtlo  in  1  write rs_val to LO
- hilo_read  in  1  ID/EX holds an MFHI/MFLO
- busy  out  1  sequencer not IDLE
- stall  out  1  pipeline hold request, combinational
- done  out  1  one-cycle pulse, HI/LO just updated by a mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States:
  - IDLE: accepts work.
  - RUN: one iteration per cycle, 5-bit down-counter from WIDTH-1 to 0.
  - FIX: sign correction and HI/LO write.
- IDLE & start → RUN:
  - Latch the operation.
  - Signed ops latch the absolute value of each operand.
  - Latch the result signs: product and quotient sign = rs[31]^rt[31]; remainder sign = rs[31]. Unsigned ops force both signs to 0.
- RUN, multiply: if the multiplier LSB is 1, add the multiplicand into the 33-bit upper accumulator; then shift the {acc, multiplier} pair right by 1.
- RUN, divide (restoring): shift {rem, quot} left by 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quot LSB=1.
- RUN with counter==0 → FIX.
- FIX, multiply: conditionally negate the 64-bit product; HI=upper word, LO=lower word.
- FIX, divide: LO=quotient and HI=remainder, each negated per its sign.
- FIX → IDLE and pulse done.
- Divide by zero (rt_val==0 at start): no exception. LO=0xFFFFFFFF, HI=rs_val as presented; sign correction is skipped.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the arithmetic naturally.
- MTHI/MTLO in IDLE: the register updates at the next edge. mthi and mtlo in the same cycle write both registers.
- start together with mthi/mtlo in IDLE: start wins and the mt writes are dropped. A single-issue pipeline never generates this.
- Any start/mthi/mtlo arriving while busy is ignored. Stall holds the instruction until the sequencer returns to IDLE, and the pipeline re-presents it.
- stall = busy & (hilo_read | start | mthi | mtlo).
- hi/lo hold their previous values throughout RUN; no partial results are visible.

## Timing
- Reset (any state, including mid-RUN): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0. Internal accumulators are cleared.
- Edge E0 samples start in IDLE. Iterations execute on edges E1..E32. FIX executes on edge E33.
- busy is high from after E0 through the cycle before E33, i.e. 33 cycles.
- hi/lo take new values and done=1 for exactly one cycle after E33.
- The result is visible 33 cycles after issue.
- stall is combinational from busy and the requests. It drops the cycle after E33, so a stalled MFHI reads the new HI in that cycle.
- A new start is accepted in the same cycle done is high: back-to-back issue, no bubble beyond the stall.
- MTHI/MTLO latency: 1 edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 cycles after the start cycle; busy high 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064, done after 33 cycles, no hang.
- Hazards: hilo_read=1 from cycle 5 of a DIVU → stall=1 until done, 0 in the done cycle. A second start at cycle 10 → stall=1, op ignored. A start presented in the done cycle → accepted.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in IDLE → hi/lo updated after 1 edge each, no stall. MTHI while busy → stall=1, hi unchanged.
- Reset asserted at RUN cycle 10 → next cycle busy=0, hi=lo=0, done never pulses. A following MULTU 6×7 → LO=42, HI=0.
